// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one external combinational ALU between NUM_REQ requesters.
// One op is accepted per cycle; each result is parked in that requester's response register.
module alu_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0] req_ctrl,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_result,
  output logic [NUM_REQ-1:0]            rsp_zero,
  output logic [DATA_WIDTH-1:0]         alu_a,
  output logic [DATA_WIDTH-1:0]         alu_b,
  output logic [CTRL_WIDTH-1:0]         alu_ctrl,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_zero,
  output logic                          busy
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = IDW + 1;

  logic                  s1_valid_reg;
  logic [IDW-1:0]        s1_id_reg;
  logic [IDW-1:0]        ptr_reg;
  logic [DATA_WIDTH-1:0] alu_a_reg;
  logic [DATA_WIDTH-1:0] alu_b_reg;
  logic [CTRL_WIDTH-1:0] alu_ctrl_reg;

  logic [NUM_REQ-1:0]    inflight;
  logic [NUM_REQ-1:0]    elig;
  logic [NUM_REQ-1:0]    grant_onehot;
  logic                  grant_any;
  logic [IDW-1:0]        grant_id;
  logic [CW-1:0]         cand;

  logic [DATA_WIDTH-1:0] a_arr    [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr    [NUM_REQ];
  logic [CTRL_WIDTH-1:0] ctrl_arr [NUM_REQ];

  // A requester may only have one op outstanding: in the ALU stage or waiting in its response slot.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] result_reg;
      logic                  zero_reg;

      assign a_arr[gi]    = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[gi]    = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
      assign ctrl_arr[gi] = req_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH];

      assign inflight[gi] = s1_valid_reg && (s1_id_reg == IDW'(gi));
      assign elig[gi]     = req_valid[gi] & ~inflight[gi] & ~valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg  <= 1'b0;
          result_reg <= '0;
          zero_reg   <= 1'b0;
        end else if (inflight[gi]) begin
          valid_reg  <= 1'b1;
          result_reg <= alu_result;
          zero_reg   <= alu_zero;
        end else if (valid_reg && rsp_ready[gi]) begin
          valid_reg  <= 1'b0;
        end
      end

      assign rsp_valid[gi]                              = valid_reg;
      assign rsp_result[gi*DATA_WIDTH +: DATA_WIDTH]    = result_reg;
      assign rsp_zero[gi]                               = zero_reg;
    end
  endgenerate

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    grant_any    = 1'b0;
    cand         = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + CW'(k);
      if (cand >= CW'(NUM_REQ)) begin
        cand = cand - CW'(NUM_REQ);
      end
      if (!grant_any && elig[cand[IDW-1:0]]) begin
        grant_any                    = 1'b1;
        grant_id                     = cand[IDW-1:0];
        grant_onehot[cand[IDW-1:0]]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_id_reg    <= '0;
      ptr_reg      <= IDW'(NUM_REQ - 1);
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      alu_ctrl_reg <= '0;
    end else begin
      s1_valid_reg <= grant_any;
      if (grant_any) begin
        s1_id_reg    <= grant_id;
        ptr_reg      <= grant_id;
        alu_a_reg    <= a_arr[grant_id];
        alu_b_reg    <= b_arr[grant_id];
        alu_ctrl_reg <= ctrl_arr[grant_id];
      end
    end
  end

  assign req_ready = grant_onehot;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_ctrl  = alu_ctrl_reg;
  assign busy      = s1_valid_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference ALU hung on the alu_* ports.
// Codes: 0000 add, 0001 sub, 0010 and, 0011 or, 0101 sll, 0110 srl, others return 0.
module tb_alu_arbiter;
  localparam int NUM_REQ    = 2;
  localparam int DATA_WIDTH = 32;
  localparam int CTRL_WIDTH = 4;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [NUM_REQ-1:0]            req_valid = '0;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b = '0;
  logic [NUM_REQ*CTRL_WIDTH-1:0] req_ctrl = '0;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_result;
  logic [NUM_REQ-1:0]            rsp_zero;
  logic [DATA_WIDTH-1:0]         alu_a;
  logic [DATA_WIDTH-1:0]         alu_b;
  logic [CTRL_WIDTH-1:0]         alu_ctrl;
  logic [DATA_WIDTH-1:0]         alu_result;
  logic                          alu_zero;
  logic                          busy;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_zero  (rsp_zero),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_result(alu_result),
    .alu_zero  (alu_zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a & alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0101: alu_result = alu_a << alu_b[4:0];
      4'b0110: alu_result = alu_a >> alu_b[4:0];
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == '0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %0d %s: observed=%0h expected=%0h", checks, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_a[i*DATA_WIDTH +: DATA_WIDTH]    = a;
    req_b[i*DATA_WIDTH +: DATA_WIDTH]    = b;
    req_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH] = c;
  endtask

  initial begin
    logic [1:0] ready_pat [3];
    logic [1:0] rspv_pat  [3];
    ready_pat[0] = 2'b10; ready_pat[1] = 2'b01; ready_pat[2] = 2'b00;
    rspv_pat[0]  = 2'b01; rspv_pat[1]  = 2'b00; rspv_pat[2]  = 2'b10;

    // Reset state
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single add on requester 0
    set_op(0, 32'd5, 32'd3, 4'b0000);
    req_valid = 2'b01;
    #1;
    check("t1_ready", req_ready, 2'b01);
    step();
    check("t1_busy", busy, 1);
    check("t1_alu_a", alu_a, 5);
    req_valid = 2'b00;
    step();
    check("t1_rsp_valid", rsp_valid, 2'b01);
    check("t1_result", rsp_result[31:0], 8);
    check("t1_zero", rsp_zero[0], 0);
    req_valid = 2'b01;
    #1;
    check("t1_no_regrant", req_ready, 2'b00);
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    step();
    check("t1_consumed", rsp_valid, 2'b00);
    check("t1_result_hold", rsp_result[31:0], 8);

    // 2: both requesters always valid; ptr=0 so requester 1 wins first
    set_op(0, 32'd10, 32'd1, 4'b0000);
    set_op(1, 32'd20, 32'd5, 4'b0001);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_ready_c%0d", i), req_ready, ready_pat[i % 3]);
      check($sformatf("t2_busy_c%0d", i), busy, (i % 3) != 0);
      if (i > 0) check($sformatf("t2_rspv_c%0d", i), rsp_valid, rspv_pat[i % 3]);
      if (i == 2) check("t2_result1", rsp_result[63:32], 15);
      if (i == 3) check("t2_result0", rsp_result[31:0], 11);
      step();
    end
    req_valid = 2'b00;
    repeat (3) step();
    check("t2_drained", {busy, rsp_valid}, 3'b000);

    // 3: requester 1 result held while not consumed
    set_op(1, 32'd7, 32'd7, 4'b0001);
    rsp_ready = 2'b00;
    req_valid = 2'b10;
    #1;
    check("t3_ready", req_ready, 2'b10);
    step();
    check("t3_inflight_ready", req_ready, 2'b00);
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid_%0d", i), rsp_valid, 2'b10);
      check($sformatf("t3_hold_ready_%0d", i), req_ready, 2'b00);
      step();
    end
    check("t3_result", rsp_result[63:32], 0);
    check("t3_zero", rsp_zero[1], 1);
    rsp_ready = 2'b10;
    #1;
    check("t3_ready_at_consume", req_ready, 2'b00);
    step();
    check("t3_consumed", rsp_valid, 2'b00);
    check("t3_regrant", req_ready, 2'b10);
    req_valid = 2'b00;
    rsp_ready = 2'b00;

    // 4: back-to-back srl on 0 then sll on 1; ptr=1 so requester 0 goes first
    set_op(0, 32'h8000_0000, 32'd1, 4'b0110);
    set_op(1, 32'd1, 32'd33, 4'b0101);
    req_valid = 2'b11;
    #1;
    check("t4_ready0", req_ready, 2'b01);
    step();
    check("t4_ready1", req_ready, 2'b10);
    check("t4_alu_a", alu_a, 32'h8000_0000);
    check("t4_alu_ctrl0", alu_ctrl, 4'b0110);
    step();
    check("t4_rsp_valid0", rsp_valid, 2'b01);
    check("t4_result0", rsp_result[31:0], 32'h4000_0000);
    check("t4_alu_ctrl1", alu_ctrl, 4'b0101);
    check("t4_ready_none", req_ready, 2'b00);
    step();
    check("t4_rsp_valid_both", rsp_valid, 2'b11);
    check("t4_result1", rsp_result[63:32], 2);
    check("t4_zero1", rsp_zero[1], 0);
    check("t4_result0_kept", rsp_result[31:0], 32'h4000_0000);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;

    // 5: undefined op code delivers 0 with zero flag
    set_op(0, 32'd9, 32'd4, 4'b1111);
    req_valid = 2'b01;
    #1;
    check("t5_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    check("t5_result", rsp_result[31:0], 0);
    check("t5_zero", rsp_zero[0], 1);
    rsp_ready = 2'b11;
    step();
    rsp_ready = 2'b00;

    // 6: reset while an op is in flight and a response is parked; ptr=0 before reset
    set_op(1, 32'd3, 32'd4, 4'b0000);
    req_valid = 2'b10;
    #1;
    check("t6_ready1", req_ready, 2'b10);
    step();
    set_op(0, 32'd1, 32'd1, 4'b0000);
    req_valid = 2'b01;
    step();
    check("t6_pre_busy", busy, 1);
    check("t6_pre_rspv", rsp_valid, 2'b10);
    req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_result", rsp_result, 0);
    check("t6_rsp_zero", rsp_zero, 0);
    check("t6_alu", {alu_a, alu_b, alu_ctrl}, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b11;
    #1;
    check("t6_first_grant", req_ready, 2'b01);
    step();
    check("t6_alu_a", alu_a, 1);
    req_valid = 2'b00;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
